// File: rtl/uart_frame_rx.sv
// Receive-side byte deframer: flag hunting, escape removal, FCS-16 check, and a 2-byte
// delay line that keeps the trailing FCS off the payload stream.
module uart_frame_rx #(
   parameter int MAX_LEN = 256,
   parameter int LEN_W   = 9
) (
   input  logic             mclk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_strobe,
   output logic [7:0]       out_data,
   output logic             out_strobe,
   output logic             out_sof,
   output logic             frame_end,
   output logic             frame_good,
   output logic [LEN_W-1:0] frame_len
);

   typedef enum logic [1:0] {HUNT, OPEN, DATA, ESC} state_t;

   state_t           state;
   logic [15:0]      crc;
   logic [7:0]       h0, h1;
   logic [1:0]       held;
   logic [LEN_W-1:0] count;

   logic       is_flag, is_esc;
   logic [7:0] d_acc;
   logic       do_close, do_accept, do_emit, overflow;

   function automatic logic [15:0] fcs16(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      return r;
   endfunction

   // Closing flag from DATA or ESC ends the frame; overflow replaces an emission.
   always_comb begin
      is_flag   = (rx_data == 8'h7E);
      is_esc    = (rx_data == 8'h7D);
      d_acc     = (state == ESC) ? (rx_data ^ 8'h20) : rx_data;
      do_close  = rx_strobe && is_flag && (state == DATA || state == ESC);
      do_accept = rx_strobe && !is_flag &&
                  (state == ESC || ((state == OPEN || state == DATA) && !is_esc));
      do_emit   = do_accept && (held == 2'd2);
      overflow  = do_emit && (count == LEN_W'(MAX_LEN));
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state      <= HUNT;
         crc        <= 16'hFFFF;
         h0         <= 8'h00;
         h1         <= 8'h00;
         held       <= 2'd0;
         count      <= '0;
         out_data   <= 8'h00;
         out_strobe <= 1'b0;
         out_sof    <= 1'b0;
         frame_end  <= 1'b0;
         frame_good <= 1'b0;
         frame_len  <= '0;
      end else begin
         out_strobe <= 1'b0;
         out_sof    <= 1'b0;
         frame_end  <= 1'b0;
         frame_good <= 1'b0;
         if (do_close || overflow) begin
            frame_end  <= 1'b1;
            frame_good <= do_close && (state == DATA) && (held == 2'd2) && (crc == 16'hF0B8);
            frame_len  <= overflow ? LEN_W'(MAX_LEN) : count;
            crc        <= 16'hFFFF;
            held       <= 2'd0;
            count      <= '0;
            state      <= overflow ? HUNT : OPEN;
         end else if (do_accept) begin
            crc   <= fcs16(crc, d_acc);
            h0    <= d_acc;
            h1    <= h0;
            held  <= (held == 2'd2) ? 2'd2 : held + 2'd1;
            state <= DATA;
            if (do_emit) begin
               out_strobe <= 1'b1;
               out_data   <= h1;
               out_sof    <= (count == '0);
               count      <= count + LEN_W'(1);
            end
         end else if (rx_strobe) begin
            if (state == HUNT && is_flag)
               state <= OPEN;
            else if ((state == OPEN || state == DATA) && is_esc)
               state <= ESC;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: two instances (MAX_LEN 256 and 4) share one byte stream and
// are compared every byte against a buffer-based model of the framing rules.
module tb_uart_frame_rx;

   localparam int W = 21;

   logic       mclk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_strobe;
   logic [7:0] od [2];
   logic       os [2], osof [2], fe [2], fg [2];
   logic [8:0] fl [2];

   uart_frame_rx #(.MAX_LEN(256), .LEN_W(9)) dut_a (
      .mclk(mclk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
      .out_data(od[0]), .out_strobe(os[0]), .out_sof(osof[0]),
      .frame_end(fe[0]), .frame_good(fg[0]), .frame_len(fl[0]));

   uart_frame_rx #(.MAX_LEN(4), .LEN_W(9)) dut_b (
      .mclk(mclk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
      .out_data(od[1]), .out_strobe(os[1]), .out_sof(osof[1]),
      .frame_end(fe[1]), .frame_good(fg[1]), .frame_len(fl[1]));

   always #5 mclk = ~mclk;

   logic [W-1:0] exp_q[$];
   logic [7:0]   pay[$];
   int checks = 0, failures = 0, gap = 0;

   // Reference model: accepted bytes of the current frame, escape and hunt flags.
   bit         m_hunt [2], m_esc [2];
   int         m_n [2];
   logic [7:0] m_buf [2][300];

   int         n_str [2], n_end [2], last_len [2];
   logic       last_good [2];
   int         b_str [2], b_end [2];

   always @(negedge mclk) begin
      for (int i = 0; i < 2; i++) begin
         if (os[i] === 1'b1) n_str[i]++;
         if (fe[i] === 1'b1) begin
            n_end[i]++;
            last_good[i] = fg[i];
            last_len[i]  = int'(fl[i]);
         end
      end
   end

   function automatic int max_len(input int i);
      return (i == 0) ? 256 : 4;
   endfunction

   function automatic logic [15:0] fcs_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if ((r[0] ^ d[k]) == 1'b1) r = (r >> 1) ^ 16'h8408;
         else r = r >> 1;
      end
      return r;
   endfunction

   function automatic logic [15:0] crc_of(input int i);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int k = 0; k < m_n[i]; k++) c = fcs_step(c, m_buf[i][k]);
      return c;
   endfunction

   function automatic logic [W-1:0] end_ev(input logic good, input int len);
      return {1'b0, 1'b0, 8'h00, 1'b1, good, 9'(len)};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_hunt[i] = 1'b1;
         m_esc[i]  = 1'b0;
         m_n[i]    = 0;
      end
   endfunction

   function automatic logic [W-1:0] model_accept(input int i, input logic [7:0] d);
      int idx;
      m_buf[i][m_n[i]] = d;
      m_n[i]++;
      if (m_n[i] < 3) return '0;
      idx = m_n[i] - 3;
      if (idx >= max_len(i)) begin
         m_hunt[i] = 1'b1;
         m_n[i]    = 0;
         return end_ev(1'b0, max_len(i));
      end
      return {1'b1, (idx == 0), m_buf[i][idx], 1'b0, 1'b0, 9'h000};
   endfunction

   function automatic logic [W-1:0] model_step(input int i, input logic [7:0] b);
      logic [W-1:0] e;
      int emitted;
      e = '0;
      emitted = (m_n[i] >= 2) ? m_n[i] - 2 : 0;
      if (m_hunt[i]) begin
         if (b == 8'h7E) begin
            m_hunt[i] = 1'b0;
            m_esc[i]  = 1'b0;
            m_n[i]    = 0;
         end
      end else if (m_esc[i]) begin
         m_esc[i] = 1'b0;
         if (b == 8'h7E) begin
            e = end_ev(1'b0, emitted);
            m_n[i] = 0;
         end else e = model_accept(i, b ^ 8'h20);
      end else if (b == 8'h7E) begin
         if (m_n[i] > 0) e = end_ev((m_n[i] >= 2) && (crc_of(i) == 16'hF0B8), emitted);
         m_n[i] = 0;
      end else if (b == 8'h7D) m_esc[i] = 1'b1;
      else e = model_accept(i, b);
      return e;
   endfunction

   function automatic logic [W-1:0] obs(input int i);
      return {os[i], osof[i], os[i] ? od[i] : 8'h00,
              fe[i], fe[i] ? fg[i] : 1'b0, fe[i] ? fl[i] : 9'h000};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      logic [W-1:0] e;
      rx_data   = b;
      rx_strobe = 1'b1;
      for (int i = 0; i < 2; i++) exp_q.push_back(model_step(i, b));
      @(negedge mclk);
      rx_strobe = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs(i) !== e) begin
            failures++;
            $display("FAIL byte dut%0d in=%02h got=%06h exp=%06h", i, b, obs(i), e);
         end
      end
      repeat (gap) begin
         @(negedge mclk);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({os[i], osof[i], fe[i]} !== 3'b000) begin
               failures++;
               $display("FAIL idle dut%0d got=%b exp=000", i, {os[i], osof[i], fe[i]});
            end
         end
      end
   endtask

   task automatic send_esc(input logic [7:0] b);
      if (b == 8'h7E || b == 8'h7D) begin
         send_byte(8'h7D);
         send_byte(b ^ 8'h20);
      end else send_byte(b);
   endtask

   task automatic send_frame(input bit bad_fcs);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (pay[k]) c = fcs_step(c, pay[k]);
      c = ~c ^ {15'h0, bad_fcs};
      send_byte(8'h7E);
      foreach (pay[k]) send_esc(pay[k]);
      send_esc(c[7:0]);
      send_esc(c[15:8]);
      send_byte(8'h7E);
   endtask

   task automatic send_case1(input logic [7:0] last_fcs);
      logic [7:0] s [12];
      s = '{8'h7E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
      s[11] = last_fcs;
      foreach (s[k]) send_byte(s[k]);
      send_byte(8'h7E);
   endtask

   task automatic snap();
      for (int i = 0; i < 2; i++) begin
         b_str[i] = n_str[i];
         b_end[i] = n_end[i];
      end
   endtask

   task automatic settle();
      repeat (2) @(negedge mclk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge mclk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({od[i], os[i], osof[i], fe[i], fg[i], fl[i]} !== '0) begin
            failures++;
            $display("FAIL reset_outputs dut%0d got=%06h exp=0", i,
                     {od[i], os[i], osof[i], fe[i], fg[i], fl[i]});
         end
      end
      reset = 1'b0;
      model_reset();
      @(negedge mclk);
   endtask

   task automatic test_good_frame();
      snap();
      send_case1(8'h90);
      settle();
      checks++;
      if (n_str[0] - b_str[0] !== 9 || last_good[0] !== 1'b1 || last_len[0] !== 9) begin
         failures++;
         $display("FAIL case1 dut0 got str=%0d good=%b len=%0d exp str=9 good=1 len=9",
                  n_str[0] - b_str[0], last_good[0], last_len[0]);
      end
      checks++;
      if (n_str[1] - b_str[1] !== 4 || last_good[1] !== 1'b0 || last_len[1] !== 4) begin
         failures++;
         $display("FAIL case1_overflow dut1 got str=%0d good=%b len=%0d exp str=4 good=0 len=4",
                  n_str[1] - b_str[1], last_good[1], last_len[1]);
      end
   endtask

   task automatic test_bad_fcs();
      snap();
      send_case1(8'h91);
      settle();
      checks++;
      if (n_str[0] - b_str[0] !== 9 || n_end[0] - b_end[0] !== 1 ||
          last_good[0] !== 1'b0 || last_len[0] !== 9) begin
         failures++;
         $display("FAIL case2 dut0 got str=%0d end=%0d good=%b len=%0d exp 9 1 0 9",
                  n_str[0] - b_str[0], n_end[0] - b_end[0], last_good[0], last_len[0]);
      end
   endtask

   task automatic test_escapes();
      snap();
      pay = '{8'h7E, 8'h7D, 8'h01};
      send_frame(1'b0);
      settle();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (n_str[i] - b_str[i] !== 3 || last_good[i] !== 1'b1 || last_len[i] !== 3) begin
            failures++;
            $display("FAIL case3 dut%0d got str=%0d good=%b len=%0d exp str=3 good=1 len=3",
                     i, n_str[i] - b_str[i], last_good[i], last_len[i]);
         end
      end
   endtask

   task automatic test_empty_frames();
      snap();
      repeat (3) send_byte(8'h7E);
      settle();
      checks++;
      if (n_str[0] - b_str[0] !== 0 || n_end[0] - b_end[0] !== 0) begin
         failures++;
         $display("FAIL case4_empty got str=%0d end=%0d exp 0 0",
                  n_str[0] - b_str[0], n_end[0] - b_end[0]);
      end
      send_byte(8'h7E);
      send_byte(8'h55);
      send_byte(8'h7E);
      settle();
      checks++;
      if (n_end[0] - b_end[0] !== 1 || last_good[0] !== 1'b0 || last_len[0] !== 0) begin
         failures++;
         $display("FAIL case4_short got end=%0d good=%b len=%0d exp 1 0 0",
                  n_end[0] - b_end[0], last_good[0], last_len[0]);
      end
   endtask

   task automatic test_overflow();
      snap();
      pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_frame(1'b0);
      settle();
      checks++;
      if (n_str[1] - b_str[1] !== 4 || n_end[1] - b_end[1] !== 1 ||
          last_good[1] !== 1'b0 || last_len[1] !== 4) begin
         failures++;
         $display("FAIL case5_overflow got str=%0d end=%0d good=%b len=%0d exp 4 1 0 4",
                  n_str[1] - b_str[1], n_end[1] - b_end[1], last_good[1], last_len[1]);
      end
      checks++;
      if (last_good[0] !== 1'b1 || last_len[0] !== 6) begin
         failures++;
         $display("FAIL case5_wide got good=%b len=%0d exp good=1 len=6", last_good[0], last_len[0]);
      end
      pay = '{8'h01};
      send_frame(1'b0);
      settle();
      checks++;
      if (last_good[1] !== 1'b1 || last_len[1] !== 1) begin
         failures++;
         $display("FAIL case5_after got good=%b len=%0d exp good=1 len=1", last_good[1], last_len[1]);
      end
   endtask

   task automatic test_abort_and_reset();
      logic [7:0] s [6];
      s = '{8'h7E, 8'h11, 8'h22, 8'h33, 8'h7D, 8'h7E};
      snap();
      foreach (s[k]) send_byte(s[k]);
      settle();
      checks++;
      if (n_str[0] - b_str[0] !== 1 || last_good[0] !== 1'b0 || last_len[0] !== 1) begin
         failures++;
         $display("FAIL case6_abort got str=%0d good=%b len=%0d exp 1 0 1",
                  n_str[0] - b_str[0], last_good[0], last_len[0]);
      end
      s = '{8'h7E, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
      foreach (s[k]) send_byte(s[k]);
      snap();
      reset = 1'b1;
      @(negedge mclk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({od[i], os[i], osof[i], fe[i], fg[i], fl[i]} !== '0) begin
            failures++;
            $display("FAIL case6_reset dut%0d got=%06h exp=0", i,
                     {od[i], os[i], osof[i], fe[i], fg[i], fl[i]});
         end
      end
      reset = 1'b0;
      model_reset();
      @(negedge mclk);
      send_case1(8'h90);
      settle();
      checks++;
      if (n_end[0] - b_end[0] !== 1 || last_good[0] !== 1'b1 || last_len[0] !== 9) begin
         failures++;
         $display("FAIL case6_after_reset got end=%0d good=%b len=%0d exp 1 1 9",
                  n_end[0] - b_end[0], last_good[0], last_len[0]);
      end
   endtask

   task automatic test_random();
      int n, r, kind;
      for (int f = 0; f < 40; f++) begin
         gap = $urandom_range(0, 2);
         pay.delete();
         n = $urandom_range(0, 12);
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 7);
            pay.push_back(r == 0 ? 8'h7E : (r == 1 ? 8'h7D : 8'($urandom)));
         end
         kind = $urandom_range(0, 5);
         if (kind == 0) send_frame(1'b1);
         else if (kind == 1) begin
            send_byte(8'h7E);
            foreach (pay[k]) send_esc(pay[k]);
            send_byte(8'h7D);
            send_byte(8'h7E);
         end else if (kind == 2) begin
            repeat ($urandom_range(1, 4)) send_byte(8'($urandom));
            send_frame(1'b0);
         end else send_frame(1'b0);
      end
      gap = 0;
   endtask

   initial begin
      reset     = 1'b1;
      rx_strobe = 1'b0;
      rx_data   = 8'h00;
      for (int i = 0; i < 2; i++) begin
         n_str[i] = 0;
         n_end[i] = 0;
         last_len[i] = 0;
         last_good[i] = 1'b0;
      end
      model_reset();
      test_reset();
      for (int g = 0; g < 2; g++) begin
         gap = (g == 0) ? 0 : 16;
         test_good_frame();
         test_bad_fcs();
         test_escapes();
         test_empty_frames();
         test_overflow();
         test_abort_and_reset();
      end
      test_random();
      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
